// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic valid/ready pipeline register with optional skid entry
// Flush kills held entries and forces NOP_CTRL; bubble counter saturates.
module pipe_stage_elastic #(
  parameter int                 DATA_W   = 128,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
  parameter bit                 SKID_EN  = 1'b1,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              bubble_clr
);

  logic              live_q, live_d;
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              in_fire, out_fire;

  // live_q holds in_ready low until the first edge after reset release
  generate
    if (SKID_EN) begin : g_skid_ready
      assign in_ready = live_q & ~skid_valid_q;
    end else begin : g_reg_ready
      assign in_ready = live_q & (~main_valid_q | out_ready);
    end
  endgenerate

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = main_valid_q & out_ready;
  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;
  assign out_ctrl   = main_valid_q ? main_ctrl_q : NOP_CTRL;
  assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign bubble_cnt = bubble_cnt_q;

  always_comb begin
    live_d       = 1'b1;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush) begin
      // payload is left in place so the last pc stays visible for debug
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire) begin
        main_valid_d = skid_valid_q;
        skid_valid_d = 1'b0;
        if (skid_valid_q) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      if (in_fire) begin
        if (!main_valid_d) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_ctrl_d  = in_ctrl;
        end else if (SKID_EN) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
          skid_ctrl_d  = in_ctrl;
        end
      end
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_clr) begin
      bubble_cnt_d = '0;
    end else if (!main_valid_q && out_ready && !flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      live_q       <= 1'b0;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= NOP_CTRL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= NOP_CTRL;
      bubble_cnt_q <= '0;
    end else begin
      live_q       <= live_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline register for any stage boundary of the core (IF/ID, ID/EX, EX/MEM, MEM/WB). It is the successor of the fixed ID/EX latch.
- Carries a generic payload bus and a generic control bus. Uses a valid/ready handshake with an optional 2-entry skid buffer, so back-pressure does not combinationally cross the stage.
- Flush forces a programmable NOP control pattern. A saturating bubble counter supports pipeline performance analysis.

Parameters:
- DATA_W, 128, payload width (pc, pc+4, operands, immediate, register indices).
- CTRL_W, 16, control width (regWrite, memRead, memWrite, branch, jal, ...).
- NOP_CTRL, 16'h0000, control pattern driven on bubbles, on flush and at reset.
- SKID_EN, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register (in_ready combinational).
- CNT_W, 16, bubble counter width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, asynchronous, active-high (reset asserted while rst_n=1).
- flush, input, 1, synchronous kill of all held entries.
- in_valid, input, 1, upstream entry valid.
- in_ready, output, 1, stage can accept an entry this cycle.
- in_data, input, DATA_W, upstream payload.
- in_ctrl, input, CTRL_W, upstream control.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, downstream accepts head this cycle.
- out_data, output, DATA_W, head payload.
- out_ctrl, output, CTRL_W, head control; equals NOP_CTRL whenever out_valid=0.
- occupancy, output, 2, number of held entries (0..2; max 1 when SKID_EN=0).
- bubble_cnt, output, CNT_W, count of cycles with out_valid=0 and out_ready=1, saturating.
- bubble_clr, input, 1, synchronous clear of bubble_cnt.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - All valid bits = 0, occupancy = 0.
  - out_data = 0, out_ctrl = NOP_CTRL, bubble_cnt = 0.
  - in_ready = 0 while in reset; it becomes 1 in the first cycle after release.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Data and ctrl are sampled only on a transfer.
  - in_valid may be held with changing data only while in_ready=0; no requirement is placed on upstream otherwise.
- Latency: an entry accepted at edge N appears on out_* after edge N (1-cycle latency), in FIFO order. There are no bypass paths.
- SKID_EN=1:
  - Storage is a main register plus a skid register.
  - in_ready = registered (occupancy<2 next cycle); equivalently, in_ready = !skid_valid.
  - Accept while main is full and out_ready=0 → entry goes to the skid register.
  - When the head is consumed, skid moves to main on the same edge.
  - Simultaneous input transfer and output transfer with occupancy=1 → main is replaced, occupancy stays 1.
  - Sustained throughput is 1 entry/cycle with no bubbles.
- SKID_EN=0:
  - in_ready = !main_valid | out_ready (combinational).
  - Behaviour is otherwise identical, with max occupancy 1.
- Stall: out_ready=0 holds out_valid, out_data and out_ctrl stable, bit-exact, until the transfer.
- Flush:
  - Flush has highest priority after reset.
  - At the edge with flush=1: both valid bits clear, occupancy = 0, out_ctrl = NOP_CTRL.
  - out_data holds its previous value; the pc field is kept for debug.
  - An input transfer in the same cycle is discarded.
  - in_ready behaves as normal during flush.
  - Flush with occupancy=0 has no effect besides re-driving NOP_CTRL.
- Bubble counter:
  - Increments when out_valid=0 & out_ready=1 & flush=0.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - bubble_clr has priority over increment.
- Reset asserted mid-transfer: all in-flight entries are lost, with no partial update. Outputs go to reset values immediately, without waiting for an edge.

Test Plan:
- Streaming: SKID_EN=1, out_ready=1, feed in_data=1..10 on 10 consecutive cycles → out_data=1..10 on the next 10 cycles, in_ready constantly 1, bubble_cnt unchanged.
- Back-pressure: load 0xA then 0xB with out_ready=0 → occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready → 0xA, then 0xB, then out_valid=0.
- Flush: occupancy=2, in_valid=1 with 0xC, flush=1 for one cycle → next cycle occupancy=0, out_valid=0, out_ctrl=NOP_CTRL, out_data keeps its old value, and 0xC never appears.
- Simultaneous: occupancy=1 holding 0x5, in 0x6 and out_ready=1 on the same cycle → out_data=0x6, occupancy=1.
- Counter: CNT_W=4, out_valid=0, out_ready=1 for 20 cycles → bubble_cnt=15 (saturated). bubble_clr=1 → 0.
- Async reset: assert rst_n=1 between edges while occupancy=2 → out_valid=0, occupancy=0 and out_ctrl=NOP_CTRL before the next edge. Repeat all of the above with SKID_EN=0 and check in_ready follows out_ready combinationally.
